// File: rtl/exec_combo_pkg.sv
// rtl/exec_combo_pkg.sv - CDB channel limits and grant helper for exec_combo
package exec_combo_pkg;

  localparam int MAX_CHANNELS = 4;

  // Index of the lowest set bit, or -1 when no channel is granted.
  function automatic int lowest_set(input logic [MAX_CHANNELS-1:0] mask);
    lowest_set = -1;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/global_variables.sv
// rtl/global_variables.sv - shared widths and ALU opcode type for the execution cluster
package global_variables;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_TAG_W = 6;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_t;

endpackage

// File: rtl/exec_combo_if.sv
// rtl/exec_combo_if.sv - operand feed and common-data-bus signals of one execution unit
interface exec_combo_if #(
  parameter int XLEN     = global_variables::DEF_XLEN,
  parameter int TAG_W    = global_variables::DEF_TAG_W,
  parameter int CHANNELS = 2
) ();

  logic                            feed_valid;
  logic                            feed_ready;
  global_variables::alu_op_t       feed_op;
  logic [XLEN-1:0]                 feed_src1;
  logic [XLEN-1:0]                 feed_src2;
  logic [TAG_W-1:0]                feed_tag;
  logic [CHANNELS-1:0][7:0]        select;
  logic                            get_bus;
  logic [CHANNELS-1:0]             cdb_valid;
  logic [CHANNELS-1:0][XLEN-1:0]   cdb_result;
  logic [CHANNELS-1:0][TAG_W-1:0]  cdb_tag;

  modport master (
    output feed_valid, feed_op, feed_src1, feed_src2, feed_tag, select,
    input  feed_ready, get_bus, cdb_valid, cdb_result, cdb_tag
  );

  modport slave (
    input  feed_valid, feed_op, feed_src1, feed_src2, feed_tag, select,
    output feed_ready, get_bus, cdb_valid, cdb_result, cdb_tag
  );

endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - integer ALU; the last of LATENCY stages is the caller's result buffer
module alu_pipe
  import global_variables::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  alu_op_t          op,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] result;

  assign shamt = src2[SW-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = src1 + src2;
      ALU_SUB:  result = src1 - src2;
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_XOR:  result = src1 ^ src2;
      ALU_SLL:  result = src1 << shamt;
      ALU_SRL:  result = src1 >> shamt;
      ALU_SRA:  result = $unsigned($signed(src1) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, src1 < src2};
      default:  result = '0;
    endcase
  end

  // The FIFO write supplies the final register, so only LATENCY-1 stages live here.
  if (LATENCY > 1) begin : g_pipe
    localparam int NS = LATENCY - 1;
    localparam int RW = NS * XLEN;
    localparam int TW = NS * TAG_W;

    logic [NS-1:0]             v_q;
    logic [NS-1:0][XLEN-1:0]   r_q;
    logic [NS-1:0][TAG_W-1:0]  t_q;

    always_ff @(posedge clock) begin
      if (reset || flush) begin
        v_q <= '0;
      end else begin
        v_q <= NS'({v_q, in_valid});
      end
      r_q <= RW'({r_q, result});
      t_q <= TW'({t_q, tag});
    end

    assign out_valid  = v_q[NS-1];
    assign out_result = r_q[NS-1];
    assign out_tag    = t_q[NS-1];
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clock, reset, flush};
    assign out_valid  = in_valid;
    assign out_result = result;
    assign out_tag    = tag;
  end

endmodule

// File: rtl/exec_combo.sv
// rtl/exec_combo.sv - ALU execution unit with in-order result FIFO and multi-channel CDB grant
module exec_combo
  import global_variables::*;
  import exec_combo_pkg::*;
#(
  parameter int         XLEN            = DEF_XLEN,
  parameter int         TAG_W           = DEF_TAG_W,
  parameter int         CHANNELS        = 2,
  parameter int         LATENCY         = 1,
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [7:0] ARBITER_ADDRESS = 8'h00
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  exec_combo_if.slave                   bus,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OW-1:0] DEPTH_V  = OW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

  logic                    feed;
  logic                    push;
  logic                    pop;
  logic                    pipe_valid;
  logic [XLEN-1:0]         pipe_result;
  logic [TAG_W-1:0]        pipe_tag;
  logic [XLEN-1:0]         mem_result [FIFO_DEPTH];
  logic [TAG_W-1:0]        mem_tag    [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [OW-1:0]           count;
  logic [OW-1:0]           occ;
  logic [MAX_CHANNELS-1:0] hit;
  int                      grant_idx;

  // occ counts in-flight results too, so the FIFO can never overflow once fed.
  assign bus.feed_ready = (occ < DEPTH_V) && !flush;
  assign full           = !bus.feed_ready;
  assign occupancy      = occ;
  assign feed           = bus.feed_valid && bus.feed_ready;
  assign push           = pipe_valid && !flush;
  assign bus.get_bus    = (count != '0) && !flush;

  alu_pipe #(
    .XLEN    (XLEN),
    .TAG_W   (TAG_W),
    .LATENCY (LATENCY)
  ) u_alu (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (feed),
    .op         (bus.feed_op),
    .src1       (bus.feed_src1),
    .src2       (bus.feed_src2),
    .tag        (bus.feed_tag),
    .out_valid  (pipe_valid),
    .out_result (pipe_result),
    .out_tag    (pipe_tag)
  );

  always_comb begin
    hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = bus.get_bus && (bus.select[c] == ARBITER_ADDRESS);
    end
    grant_idx = lowest_set(hit);
  end

  assign pop = (grant_idx >= 0);

  always_comb begin
    bus.cdb_valid  = '0;
    bus.cdb_result = '0;
    bus.cdb_tag    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_idx == c) begin
        bus.cdb_valid[c]  = 1'b1;
        bus.cdb_result[c] = mem_result[rd_ptr];
        bus.cdb_tag[c]    = mem_tag[rd_ptr];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      count <= count + OW'(push) - OW'(pop);
      occ   <= occ + OW'(feed) - OW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_result[wr_ptr] <= pipe_result;
      mem_tag[wr_ptr]    <= pipe_tag;
    end
  end

endmodule

// File: doc/exec_combo.md
EXEC_COMBO -- requirements
Module: exec_combo

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter TAG_W, default 6, destination rename-tag width.
REQ-003 SHALL have parameter CHANNELS, default 2, number of common-data-bus channels (1..4).
REQ-004 SHALL have parameter LATENCY, default 1, ALU pipeline stages (1..3).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (power of two, >= LATENCY).
REQ-006 SHALL have parameter ARBITER_ADDRESS, default 8'h00, this unit's bus-arbiter address.
REQ-007 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port flush  input  1  discard all in-flight and buffered results.
REQ-010 SHALL have ports feed_valid input 1 / feed_ready output 1  operand handshake from reservation station.
REQ-011 SHALL have ports feed_op input alu_op_t, feed_src1/feed_src2 input XLEN, feed_tag input TAG_W.
REQ-012 SHALL have port select  input  CHANNELSx8  per-channel grant address from global arbiter.
REQ-013 SHALL have port get_bus  output  1  request for a CDB channel.
REQ-014 SHALL have ports cdb_valid output CHANNELS, cdb_result output CHANNELSxXLEN, cdb_tag output CHANNELSxTAG_W.
REQ-015 SHALL have port full  output  1  equals !feed_ready.
REQ-016 SHALL have port occupancy  output  clog2(FIFO_DEPTH)+1  buffered plus in-flight results.

Function
REQ-017 SHALL accept an operation on a cycle with feed_valid && feed_ready (a "feed").
REQ-018 SHALL assert feed_ready iff occupancy < FIFO_DEPTH and flush is low.
REQ-019 SHALL compute result per alu_op_t (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU) modulo 2^XLEN; shifts use src2[clog2(XLEN)-1:0].
REQ-020 SHALL push each result with its tag into the FIFO exactly LATENCY cycles after its feed.
REQ-021 SHALL assert get_bus whenever the FIFO is non-empty and flush is low.
REQ-022 SHALL treat channel c granted when get_bus && select[c]==ARBITER_ADDRESS; with several granted, only the lowest-index channel is used.
REQ-023 SHALL, on grant of channel c, drive cdb_valid[c]=1 and FIFO-head result/tag combinationally in that cycle and pop the head at the clock edge.
REQ-024 SHALL drive cdb_valid=0 and cdb_result/cdb_tag=0 on every non-granted channel.
REQ-025 SHALL deliver results in feed order, at most one per cycle.
REQ-026 SHALL handle simultaneous push and pop in one cycle, occupancy unchanged.
REQ-027 SHALL hold the FIFO head unchanged while not granted (no loss, no duplication).
REQ-028 SHALL, on flush, clear pipeline valid bits, FIFO pointers and occupancy at the next edge; no feed accepted and no CDB drive in the flush cycle.
REQ-029 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-030 SHALL, when reset high at an edge, clear pipeline, FIFO and occupancy; outputs after reset: feed_ready=1, full=0, get_bus=0, cdb_valid=0, occupancy=0.
REQ-031 SHALL give reset priority over flush and feed; reset mid-operation discards all in-flight results.

Structure
REQ-032 SHALL take alu_op_t, XLEN and TAG_W defaults from global_variables package.
REQ-033 SHALL implement the arithmetic as sub-module alu_pipe (parametrised LATENCY, valid/tag carried alongside data); FIFO and grant logic stay in exec_combo.

Verification
REQ-034 SHALL cover: reset, then feed ADD 5+7 tag 3, select[0]=ARBITER_ADDRESS always -> cdb_valid[0] with result 12 tag 3 LATENCY cycles later.
REQ-035 SHALL cover: 4 feeds, no grant (FIFO_DEPTH=4) -> feed_ready=0, full=1, occupancy=4; grant channel 1 -> four results in order on channel 1 only.
REQ-036 SHALL cover: select[0]=select[1]=ARBITER_ADDRESS -> only cdb_valid[0]=1, one pop per cycle.
REQ-037 SHALL cover: SUB 0-1 -> 32'hFFFFFFFF; SRA 32'h80000000 by 33 -> 32'hC0000000; SLTU 1<FFFFFFFF -> 1.
REQ-038 SHALL cover: flush with 2 buffered and 1 in flight -> next cycle occupancy=0, get_bus=0, flushed results never appear on CDB.
REQ-039 SHALL cover: FIFO full, grant and feed in same cycle -> one pop, one accept next cycle, occupancy stays at FIFO_DEPTH, order preserved across pointer wrap.
